cam_ternary: RTL and testbench

- Parametrised ternary CAM, the successor to the fixed-size binary CAM: configurable data width and depth, per-entry don't-care masks, per-entry valid bits, single-entry invalidate, clear-all, and a pipelined priority-encoded search.
- Sits behind the CAM bench/dut interface family: lookup tables, tag match, flow classification.
- Search reports hit, lowest matching index, multi-hit and match count.

---
 rtl/cam_ternary.sv | 145 ++++++++++++++
 tb/tb_cam_ternary.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cam_ternary.sv
// Parametrised ternary CAM with per-entry masks and valid bits, 1-cycle read
// and a 2-stage pipelined search (match vector, then priority encode/popcount).
module cam_ternary #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_i,
  input  logic [DEPTH_LOG2-1:0] read_index_i,
  input  logic                  write_i,
  input  logic [DEPTH_LOG2-1:0] write_index_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic [DATA_WIDTH-1:0] write_mask_i,
  input  logic                  invalidate_i,
  input  logic [DEPTH_LOG2-1:0] invalidate_index_i,
  input  logic                  clear_i,
  input  logic                  search_i,
  input  logic [DATA_WIDTH-1:0] search_data_i,
  output logic                  read_valid_o,
  output logic [DATA_WIDTH-1:0] read_value_o,
  output logic [DATA_WIDTH-1:0] read_mask_o,
  output logic                  read_entry_valid_o,
  output logic                  search_valid_o,
  output logic                  search_hit_o,
  output logic [DEPTH_LOG2-1:0] search_index_o,
  output logic                  search_multi_o,
  output logic [DEPTH_LOG2:0]   search_count_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] data_r [DEPTH];
  logic [DATA_WIDTH-1:0] mask_r [DEPTH];
  logic [DEPTH-1:0]      valid_r;
  logic [DEPTH-1:0]      valid_nxt_s;
  logic [DEPTH-1:0]      wr_sel_s;
  logic [DEPTH-1:0]      inv_sel_s;
  logic [DEPTH-1:0]      match_s;
  logic [DEPTH-1:0]      match_r;
  logic                  s1_valid_r;
  logic [DEPTH_LOG2:0]   count_s;
  logic [DEPTH_LOG2-1:0] index_s;

  function automatic logic [DEPTH_LOG2:0] popcount(input logic [DEPTH-1:0] vec);
    logic [DEPTH_LOG2:0] cnt;
    cnt = {(DEPTH_LOG2+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + {{DEPTH_LOG2{1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

  // Scanning downward lets the lowest set bit overwrite any higher one.
  function automatic logic [DEPTH_LOG2-1:0] lowest_set(input logic [DEPTH-1:0] vec);
    logic [DEPTH_LOG2-1:0] idx;
    idx = {DEPTH_LOG2{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      idx = vec[i] ? i[DEPTH_LOG2-1:0] : idx;
    end
    return idx;
  endfunction

  // Clear beats invalidate beats write when deciding the next valid bits.
  assign wr_sel_s    = {{(DEPTH-1){1'b0}}, write_i} << write_index_i;
  assign inv_sel_s   = {{(DEPTH-1){1'b0}}, invalidate_i} << invalidate_index_i;
  assign valid_nxt_s = clear_i ? {DEPTH{1'b0}} : ((valid_r | wr_sel_s) & ~inv_sel_s);

  // Key/mask storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (write_i) begin
      data_r[write_index_i] <= write_data_i;
      mask_r[write_index_i] <= write_mask_i;
    end
  end

  // Valid bit register.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= {DEPTH{1'b0}};
    end else begin
      valid_r <= valid_nxt_s;
    end
  end

  // Read port: samples pre-edge contents, values hold between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_valid_o       <= 1'b0;
      read_value_o       <= {DATA_WIDTH{1'b0}};
      read_mask_o        <= {DATA_WIDTH{1'b0}};
      read_entry_valid_o <= 1'b0;
    end else begin
      read_valid_o <= read_i;
      if (read_i) begin
        read_value_o       <= data_r[read_index_i];
        read_mask_o        <= mask_r[read_index_i];
        read_entry_valid_o <= valid_r[read_index_i];
      end
    end
  end

  // Stage 1 compare against the current (pre-edge) array.
  always_comb begin
    match_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = valid_r[i] &&
                   (((search_data_i ^ data_r[i]) & ~mask_r[i]) == {DATA_WIDTH{1'b0}});
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      match_r    <= {DEPTH{1'b0}};
    end else begin
      s1_valid_r <= search_i;
      match_r    <= match_s;
    end
  end

  assign count_s = popcount(match_r);
  assign index_s = lowest_set(match_r);

  // Stage 2 result register; results hold until the next strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      search_valid_o <= 1'b0;
      search_hit_o   <= 1'b0;
      search_index_o <= {DEPTH_LOG2{1'b0}};
      search_multi_o <= 1'b0;
      search_count_o <= {(DEPTH_LOG2+1){1'b0}};
    end else begin
      search_valid_o <= s1_valid_r;
      if (s1_valid_r) begin
        search_hit_o   <= |match_r;
        search_index_o <= index_s;
        search_multi_o <= (count_s >= {{(DEPTH_LOG2-1){1'b0}}, 2'd2});
        search_count_o <= count_s;
      end
    end
  end

endmodule

// File: tb/tb_cam_ternary.sv
// Directed, table-driven self-checking bench for cam_ternary.
module tb_cam_ternary;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_i;
  logic [4:0]  read_index_i;
  logic        write_i;
  logic [4:0]  write_index_i;
  logic [31:0] write_data_i;
  logic [31:0] write_mask_i;
  logic        invalidate_i;
  logic [4:0]  invalidate_index_i;
  logic        clear_i;
  logic        search_i;
  logic [31:0] search_data_i;
  logic        read_valid_o;
  logic [31:0] read_value_o;
  logic [31:0] read_mask_o;
  logic        read_entry_valid_o;
  logic        search_valid_o;
  logic        search_hit_o;
  logic [4:0]  search_index_o;
  logic        search_multi_o;
  logic [5:0]  search_count_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cam_ternary #(.DATA_WIDTH(32), .DEPTH_LOG2(5)) dut (
    .clk(clk), .reset(reset),
    .read_i(read_i), .read_index_i(read_index_i),
    .write_i(write_i), .write_index_i(write_index_i),
    .write_data_i(write_data_i), .write_mask_i(write_mask_i),
    .invalidate_i(invalidate_i), .invalidate_index_i(invalidate_index_i),
    .clear_i(clear_i), .search_i(search_i), .search_data_i(search_data_i),
    .read_valid_o(read_valid_o), .read_value_o(read_value_o),
    .read_mask_o(read_mask_o), .read_entry_valid_o(read_entry_valid_o),
    .search_valid_o(search_valid_o), .search_hit_o(search_hit_o),
    .search_index_o(search_index_o), .search_multi_o(search_multi_o),
    .search_count_o(search_count_o)
  );

  typedef struct {
    logic        wr;   logic [4:0] widx; logic [31:0] wdata; logic [31:0] wmask;
    logic        inv;  logic [4:0] iidx; logic clr;
    logic        rd;   logic [4:0] ridx;
    logic        srch; logic [31:0] sdata;
    logic        chk_rdat; logic exp_rev; logic [31:0] exp_rval; logic [31:0] exp_rmask;
    logic        exp_hit; logic [4:0] exp_idx; logic exp_multi; logic [5:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; read_i = 1'b0; read_index_i = 5'd0;
    write_i = 1'b0; write_index_i = 5'd0; write_data_i = 32'd0; write_mask_i = 32'd0;
    invalidate_i = 1'b0; invalidate_index_i = 5'd0; clear_i = 1'b0;
    search_i = 1'b0; search_data_i = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_search(input string name, input logic hit, input logic [4:0] idx,
                            input logic multi, input logic [5:0] cnt);
    chk({name, ".valid"}, {63'd0, search_valid_o}, 64'd1);
    chk({name, ".hit"},   {63'd0, search_hit_o},   {63'd0, hit});
    chk({name, ".index"}, {59'd0, search_index_o}, {59'd0, idx});
    chk({name, ".multi"}, {63'd0, search_multi_o}, {63'd0, multi});
    chk({name, ".count"}, {58'd0, search_count_o}, {58'd0, cnt});
  endtask

  function automatic vec_t v_none();
    vec_t v;
    v = '{default: 0};
    return v;
  endfunction

  function automatic vec_t v_wr(input logic [4:0] idx, input logic [31:0] d, input logic [31:0] m);
    vec_t v;
    v = v_none(); v.wr = 1'b1; v.widx = idx; v.wdata = d; v.wmask = m;
    return v;
  endfunction

  function automatic vec_t v_s(input vec_t b, input logic [31:0] key, input logic hit,
                               input logic [4:0] idx, input logic multi, input logic [5:0] cnt);
    vec_t v;
    v = b; v.srch = 1'b1; v.sdata = key;
    v.exp_hit = hit; v.exp_idx = idx; v.exp_multi = multi; v.exp_cnt = cnt;
    return v;
  endfunction

  function automatic vec_t v_rd(input vec_t b, input logic [4:0] idx, input logic ev,
                                input logic cd, input logic [31:0] val, input logic [31:0] msk);
    vec_t v;
    v = b; v.rd = 1'b1; v.ridx = idx; v.exp_rev = ev;
    v.chk_rdat = cd; v.exp_rval = val; v.exp_rmask = msk;
    return v;
  endfunction

  initial begin
    vec_t v;
    // Vector table: each record is one request cycle followed by one idle cycle.
    vecs.push_back(v_rd(v_s(v_none(), 32'h0000_0000, 1'b0, 5'd0, 1'b0, 6'd0),
                        5'd3, 1'b0, 1'b0, 32'd0, 32'd0));
    vecs.push_back(v_wr(5'd5, 32'hDEAD_BEEF, 32'h0000_0000));
    vecs.push_back(v_s(v_none(), 32'hDEAD_BEEF, 1'b1, 5'd5, 1'b0, 6'd1));
    vecs.push_back(v_s(v_none(), 32'hDEAD_BEEE, 1'b0, 5'd0, 1'b0, 6'd0));
    vecs.push_back(v_wr(5'd2, 32'h1234_0000, 32'h0000_FFFF));
    vecs.push_back(v_wr(5'd9, 32'h1234_5678, 32'h0000_0000));
    vecs.push_back(v_s(v_none(), 32'h1234_5678, 1'b1, 5'd2, 1'b1, 6'd2));
    vecs.push_back(v_s(v_wr(5'd7, 32'hA5A5_A5A5, 32'h0), 32'hA5A5_A5A5, 1'b0, 5'd0, 1'b0, 6'd0));
    vecs.push_back(v_s(v_none(), 32'hA5A5_A5A5, 1'b1, 5'd7, 1'b0, 6'd1));
    v = v_wr(5'd4, 32'h0BAD_F00D, 32'h0000_00FF); v.inv = 1'b1; v.iidx = 5'd4;
    vecs.push_back(v);
    vecs.push_back(v_rd(v_none(), 5'd4, 1'b0, 1'b1, 32'h0BAD_F00D, 32'h0000_00FF));
    vecs.push_back(v_rd(v_wr(5'd5, 32'h1111_1111, 32'h0), 5'd5, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0));
    vecs.push_back(v_rd(v_none(), 5'd5, 1'b1, 1'b1, 32'h1111_1111, 32'h0));
    v = v_wr(5'd10, 32'h1234_5678, 32'h0); v.inv = 1'b1; v.iidx = 5'd9;
    vecs.push_back(v);
    vecs.push_back(v_s(v_none(), 32'h1234_5678, 1'b1, 5'd2, 1'b1, 6'd2));

    idle();
    reset = 1'b1;
    tick(); tick();
    chk("rst.read_valid", {63'd0, read_valid_o}, 64'd0);
    chk("rst.search_valid", {63'd0, search_valid_o}, 64'd0);
    chk("rst.search_count", {58'd0, search_count_o}, 64'd0);
    idle();

    foreach (vecs[k]) begin
      v = vecs[k];
      write_i = v.wr; write_index_i = v.widx; write_data_i = v.wdata; write_mask_i = v.wmask;
      invalidate_i = v.inv; invalidate_index_i = v.iidx; clear_i = v.clr;
      read_i = v.rd; read_index_i = v.ridx; search_i = v.srch; search_data_i = v.sdata;
      tick();
      idle();
      if (v.rd) begin
        chk($sformatf("v%0d.read_valid", k), {63'd0, read_valid_o}, 64'd1);
        chk($sformatf("v%0d.entry_valid", k), {63'd0, read_entry_valid_o}, {63'd0, v.exp_rev});
        if (v.chk_rdat) begin
          chk($sformatf("v%0d.read_value", k), {32'd0, read_value_o}, {32'd0, v.exp_rval});
          chk($sformatf("v%0d.read_mask", k), {32'd0, read_mask_o}, {32'd0, v.exp_rmask});
        end
      end
      tick();
      if (v.srch) begin
        chk_search($sformatf("v%0d", k), v.exp_hit, v.exp_idx, v.exp_multi, v.exp_cnt);
      end else begin
        chk($sformatf("v%0d.no_strobe", k), {63'd0, search_valid_o}, 64'd0);
      end
    end
    chk("hold.read_valid", {63'd0, read_valid_o}, 64'd0);
    chk("hold.read_value", {32'd0, read_value_o}, {32'd0, 32'h1111_1111});

    // Fill every entry with an all-don't-care mask.
    for (int i = 0; i < 32; i++) begin
      write_i = 1'b1; write_index_i = i[4:0]; write_data_i = i * 3; write_mask_i = 32'hFFFF_FFFF;
      tick();
    end
    idle();

    // Back-to-back searches with invalidates landing behind each compare.
    search_i = 1'b1; search_data_i = 32'h5555_AAAA; invalidate_i = 1'b1; invalidate_index_i = 5'd0;
    tick();
    invalidate_index_i = 5'd1;
    tick();
    chk_search("pipe0", 1'b1, 5'd0, 1'b1, 6'd32);
    invalidate_i = 1'b0;
    tick();
    idle();
    chk_search("pipe1", 1'b1, 5'd1, 1'b1, 6'd31);
    tick();
    chk_search("pipe2", 1'b1, 5'd2, 1'b1, 6'd30);

    // Clear overrides a same-cycle write's valid-set; its data still lands.
    clear_i = 1'b1; write_i = 1'b1; write_index_i = 5'd11;
    write_data_i = 32'hCAFE_0011; write_mask_i = 32'hFFFF_FFFF;
    invalidate_i = 1'b1; invalidate_index_i = 5'd3;
    tick();
    idle();
    search_i = 1'b1; search_data_i = 32'h0000_0000; read_i = 1'b1; read_index_i = 5'd11;
    tick();
    idle();
    chk("clr.entry_valid", {63'd0, read_entry_valid_o}, 64'd0);
    chk("clr.read_value", {32'd0, read_value_o}, {32'd0, 32'hCAFE_0011});
    tick();
    chk_search("clr", 1'b0, 5'd0, 1'b0, 6'd0);

    // Produce a nonzero hit so reset has something to clear.
    write_i = 1'b1; write_index_i = 5'd12; write_data_i = 32'h0; write_mask_i = 32'hFFFF_FFFF;
    tick();
    idle();
    search_i = 1'b1;
    tick();
    idle();
    tick();
    chk_search("pre_rst", 1'b1, 5'd12, 1'b0, 6'd1);

    // Search, then reset on the next cycle (with a competing write).
    search_i = 1'b1; read_i = 1'b1; read_index_i = 5'd11;
    tick();
    idle();
    reset = 1'b1; write_i = 1'b1; write_index_i = 5'd6; write_mask_i = 32'hFFFF_FFFF; search_i = 1'b1;
    tick();
    idle();
    chk("rst2.search_valid", {63'd0, search_valid_o}, 64'd0);
    chk("rst2.hit", {63'd0, search_hit_o}, 64'd0);
    chk("rst2.index", {59'd0, search_index_o}, 64'd0);
    chk("rst2.count", {58'd0, search_count_o}, 64'd0);
    chk("rst2.read_value", {32'd0, read_value_o}, 64'd0);
    chk("rst2.read_valid", {63'd0, read_valid_o}, 64'd0);
    read_i = 1'b1; read_index_i = 5'd6;
    tick();
    idle();
    chk("rst2.no_late_strobe", {63'd0, search_valid_o}, 64'd0);
    chk("rst2.entry6_valid", {63'd0, read_entry_valid_o}, 64'd0);
    tick();
    chk("rst2.still_no_strobe", {63'd0, search_valid_o}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
